// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding and baud divisor.
// The transmitter uses the same package for its baud divisor and frame constants.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int calc_baud_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into clk: two-flop synchroniser plus
// a previous-value flop for falling-edge detection. All flops reset to idle-high.
module uart_rx_sync
(
    input  logic clk,
    input  logic rst_n,
    input  logic rs232_rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rs232_rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_sync = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detection, mid-bit sampling on an internal
// baud counter, one-cycle done / framing-error strobes.
//
// state | meaning
// IDLE  | line idle, waiting for a synchronised 1->0 edge
// START | counting to mid start bit; a high sample there is a glitch
// DATA  | sampling eight data bits LSB first, one per bit period
// STOP  | sampling the stop bit; high delivers the byte, low flags an error
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_d,
    output logic       rx_done,
    output logic       rx_err,
    output logic       rx_busy,
    output logic [3:0] rx_num
);

    localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD);
    localparam int HALF_CNT = BAUD_CNT / 2;
    localparam int CNT_W    = $clog2(BAUD_CNT) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
    localparam logic [3:0]       NUM_DLAST = 4'(DATA_BITS);
    localparam logic [3:0]       NUM_STOP  = 4'(FRAME_BITS - 1);

    logic                 rx_sync;
    logic                 rx_fall;
    uart_state_t          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [7:0]           rx_d_q;
    logic                 rx_done_q;
    logic                 rx_err_q;
    logic                 rx_busy_q;
    logic [3:0]           rx_num_q;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs232_rx (rs232_rx),
        .rx_sync  (rx_sync),
        .rx_fall  (rx_fall)
    );

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            rx_d_q    <= 8'h00;
            rx_done_q <= 1'b0;
            rx_err_q  <= 1'b0;
            rx_busy_q <= 1'b0;
            rx_num_q  <= 4'd0;
        end else begin
            rx_done_q <= 1'b0;
            rx_err_q  <= 1'b0;
            cnt_q     <= cnt_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_fall) begin
                        rx_busy_q <= 1'b1;
                        rx_num_q  <= 4'd0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        if (!rx_sync) begin
                            cnt_q    <= '0;
                            rx_num_q <= 4'd1;
                            state_q  <= DATA;
                        end else begin
                            rx_busy_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync, shift_q[DATA_BITS-1:1]};
                        if (rx_num_q == NUM_DLAST) begin
                            rx_num_q <= NUM_STOP;
                            state_q  <= STOP;
                        end else begin
                            rx_num_q <= rx_num_q + 4'd1;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        rx_busy_q <= 1'b0;
                        rx_num_q  <= 4'd0;
                        state_q   <= IDLE;
                        if (rx_sync) begin
                            rx_d_q    <= shift_q;
                            rx_done_q <= 1'b1;
                        end else begin
                            rx_err_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_d    = rx_d_q;
    assign rx_done = rx_done_q;
    assign rx_err  = rx_err_q;
    assign rx_busy = rx_busy_q;
    assign rx_num  = rx_num_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clk/bit: frame scoreboard, strobe
// timing, glitch rejection, framing errors, reset mid-frame and baud tolerance.
module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLK  = CLK_FREQ / BAUD;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_d;
    logic       rx_done;
    logic       rx_err;
    logic       rx_busy;
    logic [3:0] rx_num;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs232_rx (rs232_rx),
        .rx_d     (rx_d),
        .rx_done  (rx_done),
        .rx_err   (rx_err),
        .rx_busy  (rx_busy),
        .rx_num   (rx_num)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation side: strobes, busy run lengths and rx_num changes.
    int         cyc = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         busy_runs[$];
    logic [3:0] num_log[$];
    int         err_seen  = 0;
    int         both_seen = 0;
    int         busy_run  = 0;
    logic [3:0] num_prev  = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            got_q.push_back(rx_d);
            got_cyc.push_back(cyc);
        end
        if (rx_err) err_seen <= err_seen + 1;
        if (rx_done && rx_err) both_seen <= both_seen + 1;
        if (rx_busy) busy_run <= busy_run + 1;
        else begin
            if (busy_run != 0) busy_runs.push_back(busy_run);
            busy_run <= 0;
        end
        if (rx_num != num_prev) num_log.push_back(rx_num);
        num_prev <= rx_num;
    end

    // Reference: a frame delivers its byte iff its stop bit is high; otherwise one error.
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         exp_err   = 0;

    task automatic drive_bits(input logic v, input int n);
        rs232_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int len, input logic stop_bit,
                              output int fall_cyc);
        fall_cyc = cyc;
        drive_bits(1'b0, len);
        for (int i = 0; i < 8; i++) drive_bits(b[i], len);
        drive_bits(stop_bit, len);
        if (stop_bit) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_err++;
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        busy_runs.delete();
        num_log.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rs232_rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_d !== 8'h00) begin errors++; $display("FAIL reset_rx_d: got %h want 00", rx_d); end
        checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_rx_err: got %b want 0", rx_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
        checks++; if (rx_num !== 4'd0) begin errors++; $display("FAIL reset_rx_num: got %0d want 0", rx_num); end
        rst_n = 1'b1;
        drive_bits(1'b1, 10);
    endtask

    task automatic test_single_frame();
        int fall;
        int e0;
        int lat;
        bit num_ok;
        clear_obs();
        e0 = err_seen;
        send_frame(8'hA5, BIT_CLK, 1'b1, fall);
        drive_bits(1'b1, 20);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL single_byte: got %h want a5", got_q[0]); end
            lat = got_cyc[0] - fall;
            checks++; if (lat < 153 || lat > 157) begin errors++; $display("FAIL single_latency: got %0d want 153..157", lat); end
        end
        checks++; if (rx_d !== 8'hA5) begin errors++; $display("FAIL single_rx_d_held: got %h want a5", rx_d); end
        checks++; if (err_seen != e0) begin errors++; $display("FAIL single_no_err: got %0d errs want 0", err_seen - e0); end
        num_ok = (num_log.size() == 10);
        for (int i = 0; i < num_log.size() && i < 10; i++)
            if (num_log[i] !== ((i < 9) ? 4'(i + 1) : 4'd0)) num_ok = 0;
        checks++; if (!num_ok) begin errors++; $display("FAIL single_rx_num_steps: got %0d changes, want 1..9 then 0", num_log.size()); end
    endtask

    task automatic test_back_to_back();
        int fall;
        int e0;
        logic [7:0] bytes [3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        clear_obs();
        e0 = err_seen;
        for (int i = 0; i < 3; i++) send_frame(bytes[i], BIT_CLK, 1'b1, fall);
        drive_bits(1'b1, 20);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (err_seen != e0) begin errors++; $display("FAIL b2b_no_err: got %0d errs want 0", err_seen - e0); end
    endtask

    task automatic test_start_glitch();
        int fall;
        int e0;
        clear_obs();
        e0 = err_seen;
        drive_bits(1'b0, 4);
        drive_bits(1'b1, 40);
        checks++; if (got_q.size() != 0 || err_seen != e0) begin errors++; $display("FAIL glitch_no_strobe: got %0d done %0d err want 0 0", got_q.size(), err_seen - e0); end
        checks++; if (busy_runs.size() != 1 || (busy_runs.size() == 1 && busy_runs[0] > 9)) begin
            errors++; $display("FAIL glitch_busy_run: got %0d runs first %0d want 1 run <= 9", busy_runs.size(), (busy_runs.size() > 0) ? busy_runs[0] : -1);
        end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_idle: got %b want 0", rx_busy); end
        send_frame(8'h3C, BIT_CLK, 1'b1, fall);
        drive_bits(1'b1, 20);
        checks++; if (got_q.size() != 1 || rx_d !== 8'h3C) begin errors++; $display("FAIL glitch_then_3c: got %0d frames rx_d %h want 1 3c", got_q.size(), rx_d); end
    endtask

    task automatic test_bad_stop();
        int fall;
        int e0;
        int busy_hits;
        logic [7:0] prev;
        clear_obs();
        e0 = err_seen;
        prev = rx_d;
        send_frame(8'h81, BIT_CLK, 1'b0, fall);
        busy_hits = 0;
        rs232_rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_busy) busy_hits++;
        end
        checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL badstop_err_pulse: got %0d want 1", err_seen - e0); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL badstop_no_done: got %0d want 0", got_q.size()); end
        checks++; if (rx_d !== prev) begin errors++; $display("FAIL badstop_rx_d_kept: got %h want %h", rx_d, prev); end
        checks++; if (busy_hits != 0) begin errors++; $display("FAIL badstop_break_no_start: got %0d busy cycles want 0", busy_hits); end
        drive_bits(1'b1, 20);
        send_frame(8'h7E, BIT_CLK, 1'b1, fall);
        drive_bits(1'b1, 20);
        checks++; if (got_q.size() != 1 || rx_d !== 8'h7E) begin errors++; $display("FAIL badstop_recover: got %0d frames rx_d %h want 1 7e", got_q.size(), rx_d); end
    endtask

    task automatic test_reset_mid_frame();
        int fall;
        int e0;
        logic [7:0] b;
        clear_obs();
        e0 = err_seen;
        b = 8'hF0;
        drive_bits(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive_bits(b[i], BIT_CLK);
        drive_bits(b[4], BIT_CLK / 2);
        rs232_rx = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (rx_busy !== 1'b0 || rx_num !== 4'd0) begin errors++; $display("FAIL midrst_busy_num: got %b %0d want 0 0", rx_busy, rx_num); end
        checks++; if (rx_d !== 8'h00 || rx_done !== 1'b0 || rx_err !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got %h %b %b want 00 0 0", rx_d, rx_done, rx_err); end
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_bits(1'b1, 200);
        checks++; if (got_q.size() != 0 || err_seen != e0) begin errors++; $display("FAIL midrst_no_strobe: got %0d done %0d err want 0 0", got_q.size(), err_seen - e0); end
        send_frame(8'h0F, BIT_CLK, 1'b1, fall);
        drive_bits(1'b1, 20);
        checks++; if (got_q.size() != 1 || rx_d !== 8'h0F) begin errors++; $display("FAIL midrst_then_0f: got %0d frames rx_d %h want 1 0f", got_q.size(), rx_d); end
    endtask

    task automatic test_baud_tolerance();
        int fall;
        int e0;
        int lens [2];
        lens[0] = BIT_CLK - 1; lens[1] = BIT_CLK + 1;
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            e0 = err_seen;
            send_frame(8'hC3, lens[k], 1'b1, fall);
            drive_bits(1'b1, 30);
            checks++; if (got_q.size() != 1 || rx_d !== 8'hC3) begin errors++; $display("FAIL tol_%0dclk: got %0d frames rx_d %h want 1 c3", lens[k], got_q.size(), rx_d); end
            checks++; if (err_seen != e0) begin errors++; $display("FAIL tol_%0dclk_err: got %0d want 0", lens[k], err_seen - e0); end
            drive_bits(1'b1, 10);
        end
    endtask

    task automatic test_random();
        int fall;
        int e0;
        int exp_err0;
        logic [7:0] b;
        logic good;
        int gap;
        clear_obs();
        e0 = err_seen;
        exp_err0 = exp_err;
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 12);
            if (!good) gap = gap + 4;
            send_frame(b, BIT_CLK, good, fall);
            if (gap > 0) drive_bits(1'b1, gap);
        end
        drive_bits(1'b1, 30);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (err_seen - e0 != exp_err - exp_err0) begin errors++; $display("FAIL rand_errs: got %0d want %0d", err_seen - e0, exp_err - exp_err0); end
        checks++; if (rx_d !== last_good) begin errors++; $display("FAIL rand_rx_d_last: got %h want %h", rx_d, last_good); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_start_glitch();
        test_bad_stop();
        test_reset_mid_frame();
        test_baud_tolerance();
        test_random();
        checks++; if (both_seen != 0) begin errors++; $display("FAIL done_err_exclusive: got %0d overlaps want 0", both_seen); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
